cipher_xfer_ctrl: RTL and testbench

- Sequences one full encrypt/decrypt job on the soft CPU:
  - copies the 108-entry keyboard character buffer into CPU data memory;
  - writes the shift amount and program select;
  - runs the CPU until it flags completion;
  - reads the result region back into the VGA read buffer.
- Sits between the keyboard/VGA front end and the processor wrapper.
- Is the sole master of the wrapper's debug memory port while a job is active.

---
 rtl/cipher_xfer_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_cipher_xfer_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_xfer_ctrl.sv
// Job sequencer: loads keyboard characters into CPU memory, runs the CPU, reads results back.
// Optional macro XFER_SKIP_BLANK_EN maps bytes below 8'h21 to 8'h20 in both directions.
module cipher_xfer_ctrl #(
   parameter int N_CHARS   = 108,
   parameter int ADDR_W    = 12,
   parameter int WR_BASE   = 3000,
   parameter int RD_BASE   = 3500,
   parameter int CFG_ADDR  = 2999,
   parameter int TIMEOUT_W = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_enc,
   input  logic              start_dec,
   input  logic [4:0]        shift_amt,
   output logic [6:0]        buf_rd_addr,
   input  logic [7:0]        buf_rd_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [31:0]       mem_rdata,
   output logic [1:0]        cpu_en,
   output logic [1:0]        program_sel,
   input  logic              cpu_done,
   output logic              rb_we,
   output logic [6:0]        rb_addr,
   output logic [7:0]        rb_data,
   output logic              busy,
   output logic              done,
   output logic              timeout
);

   typedef enum logic [2:0] {IDLE, LOAD, CFG, RUN, READ, RWAIT, DONE} state_t;

   localparam logic [6:0]        LAST_IDX = 7'(N_CHARS - 1);
   localparam logic [ADDR_W-1:0] WR_A     = ADDR_W'(WR_BASE);
   localparam logic [ADDR_W-1:0] RD_A     = ADDR_W'(RD_BASE);
   localparam logic [ADDR_W-1:0] CFG_A    = ADDR_W'(CFG_ADDR);

   if ((N_CHARS < 1) || (N_CHARS > 128) ||
       (WR_BASE + N_CHARS > 2**ADDR_W) || (RD_BASE + N_CHARS > 2**ADDR_W) ||
       (CFG_ADDR >= 2**ADDR_W)) begin : g_param_check
      $error("cipher_xfer_ctrl: character regions do not fit the address space");
   end

   function automatic logic [7:0] blank_fix(input logic [7:0] ch);
`ifdef XFER_SKIP_BLANK_EN
      return (ch < 8'h21) ? 8'h20 : ch;
`else
      return ch;
`endif
   endfunction

   state_t                state_q, state_d;
   logic [6:0]            idx_q, idx_d;
   logic [TIMEOUT_W-1:0]  wd_q, wd_d;
   logic [1:0]            prog_q, prog_d;
   logic [4:0]            shift_q, shift_d;
   logic                  timeout_q, timeout_d;
   logic [1:0]            cpu_en_q, cpu_en_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;
   logic                  mem_we_q, mem_we_d;
   logic                  mem_re_q, mem_re_d;
   logic                  rb_we_q, rb_we_d;
   logic [6:0]            rb_addr_q, rb_addr_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  unused_rdata_hi;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d   = state_q;
      idx_d     = idx_q;
      wd_d      = wd_q;
      prog_d    = prog_q;
      shift_d   = shift_q;
      timeout_d = timeout_q;

      case (state_q)
         IDLE: begin
            if (start_enc || start_dec) begin
               prog_d    = start_enc ? 2'b01 : 2'b10;
               shift_d   = shift_amt;
               timeout_d = 1'b0;
               idx_d     = '0;
               state_d   = LOAD;
            end
         end
         LOAD: begin
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = CFG;
            end else begin
               idx_d = idx_q + 7'd1;
            end
         end
         CFG: begin
            wd_d    = '0;
            state_d = RUN;
         end
         RUN: begin
            // The first RUN cycle has wd_q == 0; a done flag left over from the last job is ignored there.
            if (cpu_done && (wd_q != '0)) begin
               idx_d   = '0;
               state_d = READ;
            end else if (wd_q == '1) begin
               timeout_d = 1'b1;
               idx_d     = '0;
               state_d   = READ;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         READ:  state_d = RWAIT;
         RWAIT: begin
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 7'd1;
               state_d = READ;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Registered outputs are decoded from the next state so they line up with the state they belong to.
      cpu_en_d    = 2'b00;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      mem_we_d    = 1'b0;
      mem_re_d    = 1'b0;
      rb_we_d     = 1'b0;
      rb_addr_d   = '0;
      case (state_d)
         LOAD: begin
            cpu_en_d    = 2'b01;
            mem_we_d    = 1'b1;
            mem_addr_d  = WR_A + ADDR_W'(idx_d);
            mem_wdata_d = {24'b0, blank_fix(buf_rd_data)};
         end
         CFG: begin
            cpu_en_d    = 2'b01;
            mem_we_d    = 1'b1;
            mem_addr_d  = CFG_A;
            mem_wdata_d = {25'b0, prog_d, shift_d};
         end
         RUN:  cpu_en_d = 2'b10;
         READ: begin
            mem_re_d   = 1'b1;
            mem_addr_d = RD_A + ADDR_W'(idx_d);
         end
         RWAIT: begin
            rb_we_d   = 1'b1;
            rb_addr_d = idx_d;
         end
         default: ;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         wd_q        <= '0;
         prog_q      <= 2'b00;
         shift_q     <= '0;
         timeout_q   <= 1'b0;
         cpu_en_q    <= 2'b00;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         rb_we_q     <= 1'b0;
         rb_addr_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         wd_q        <= wd_d;
         prog_q      <= prog_d;
         shift_q     <= shift_d;
         timeout_q   <= timeout_d;
         cpu_en_q    <= cpu_en_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
         rb_we_q     <= rb_we_d;
         rb_addr_q   <= rb_addr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Read data is already registered by the memory; forwarding it lets the buffer write land
   // in RWAIT itself, so it never overlaps the next read strobe.
   assign rb_data         = rb_we_q ? blank_fix(mem_rdata[7:0]) : 8'h00;
   assign unused_rdata_hi = ^mem_rdata[31:8];

   assign buf_rd_addr = idx_d;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_we      = mem_we_q;
   assign mem_re      = mem_re_q;
   assign cpu_en      = cpu_en_q;
   assign program_sel = prog_q;
   assign rb_we       = rb_we_q;
   assign rb_addr     = rb_addr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_cipher_xfer_ctrl.sv
// Directed bench for cipher_xfer_ctrl with a behavioural memory, keyboard buffer and CPU model.
// The watchdog is shortened to TIMEOUT_W = 6 so a timeout run stays short.
module tb_cipher_xfer_ctrl;
   localparam int N  = 108;
   localparam int AW = 12;
   localparam int TW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_enc = 1'b0, start_dec = 1'b0;
   logic [4:0]    shift_amt = '0;
   logic [6:0]    buf_rd_addr;
   logic [7:0]    buf_rd_data;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata = '0;
   logic          mem_we, mem_re, cpu_done, rb_we, busy, done, timeout;
   logic [1:0]    cpu_en, program_sel;
   logic [6:0]    rb_addr;
   logic [7:0]    rb_data;

   always #5 clk = ~clk;

   cipher_xfer_ctrl #(.TIMEOUT_W(TW)) dut (
      .clk(clk), .reset(rst_n), .start_enc(start_enc), .start_dec(start_dec),
      .shift_amt(shift_amt), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .cpu_en(cpu_en), .program_sel(program_sel),
      .cpu_done(cpu_done), .rb_we(rb_we), .rb_addr(rb_addr), .rb_data(rb_data),
      .busy(busy), .done(done), .timeout(timeout)
   );

   // Keyboard buffer, combinational read.
   logic [7:0] kbuf [N];
   assign buf_rd_data = (int'(buf_rd_addr) < N) ? kbuf[buf_rd_addr] : 8'h00;

   // Memory plus CPU model: mode 0 finishes 50 cycles into RUN, 1 never finishes,
   // 2 holds a stale done on RUN entry, drops it, and raises it again 20 cycles in.
   logic [31:0] mem [4096];
   int          cpu_mode = 0;
   int          run_cyc = 0;
   logic [7:0]  cpu_shift = '0;
   logic        poke = 1'b0;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
      run_cyc <= (cpu_en == 2'b10) ? run_cyc + 1 : 0;
      if (cpu_en == 2'b10 && run_cyc == 1) begin
         for (int k = 0; k < N; k++) mem[3500 + k] <= {24'b0, mem[3000 + k][7:0] + cpu_shift};
         if (poke) begin
            mem[3500] <= 32'h0000_0000;
            mem[3501] <= 32'h0000_0041;
         end
      end
   end

   always_comb begin
      case (cpu_mode)
         0:       cpu_done = (cpu_en == 2'b10) && (run_cyc >= 50);
         1:       cpu_done = 1'b0;
         default: cpu_done = (cpu_en != 2'b10) || (run_cyc == 0) || (run_cyc >= 20);
      endcase
   end

   // Passive monitors, sampled away from the active edge.
   logic [7:0] rb [N];
   int run_len = 0, rb_cnt = 0, wr_cnt = 0, done_cnt = 0, overlap = 0;
   always @(negedge clk) begin
      if (cpu_en == 2'b10) run_len++;
      if (rb_we && int'(rb_addr) < N) begin
         rb[rb_addr] = rb_data;
         rb_cnt++;
      end
      if (mem_we && mem_addr >= 12'd3000 && mem_addr < 12'd3108) wr_cnt++;
      if (done) done_cnt++;
      if (int'(mem_we) + int'(mem_re) + int'(rb_we) > 1) overlap++;
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_job(input logic enc, input logic dec, input logic [4:0] sh);
      shift_amt = sh;
      start_enc = enc;
      start_dec = dec;
      @(negedge clk);
      start_enc = 1'b0;
      start_dec = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(done), 32'd1);
      @(negedge clk);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int rl0, rb0, dc0, bad, n;
      for (int k = 0; k < N; k++) kbuf[k] = 8'h41 + 8'(k % 12);
      for (int k = 0; k < 4096; k++) mem[k] = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cpu_en", 32'(cpu_en), 32'd0);
      check("rst_prog", 32'(program_sel), 32'd0);
      check("rst_strobes", {29'b0, mem_we, mem_re, rb_we}, 32'd0);
      check("rst_done_to", {30'b0, done, timeout}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Encrypt job, shift 3: "A".."L" in, "D".."O" out
      cpu_mode = 0; cpu_shift = 8'd3;
      rl0 = run_len; rb0 = rb_cnt; dc0 = done_cnt;
      start_job(1'b1, 1'b0, 5'd3);
      shift_amt = 5'd31;
      check("enc_first_we", 32'(mem_we), 32'd1);
      check("enc_first_addr", 32'(mem_addr), 32'd3000);
      check("enc_first_data", mem_wdata, 32'h41);
      check("enc_cpu_en_load", 32'(cpu_en), 32'd1);
      check("enc_prog", 32'(program_sel), 32'd1);
      wait_done("enc_done");
      check("enc_wr_cnt", 32'(wr_cnt), 32'd108);
      check("enc_cfg_word", mem[2999], 32'h0000_0023);
      bad = 0;
      for (int k = 0; k < N; k++) if (mem[3000 + k] !== {24'b0, 8'h41 + 8'(k % 12)}) bad++;
      check("enc_mem_image", 32'(bad), 32'd0);
      bad = 0;
      for (int k = 0; k < N; k++) if (rb[k] !== 8'h44 + 8'(k % 12)) bad++;
      check("enc_rb_image", 32'(bad), 32'd0);
      check("enc_rb_cnt", 32'(rb_cnt - rb0), 32'd108);
      check("enc_run_len", 32'(run_len - rl0), 32'd51);
      check("enc_done_cnt", 32'(done_cnt - dc0), 32'd1);
      check("enc_timeout", 32'(timeout), 32'd0);
      check("enc_prog_hold", 32'(program_sel), 32'd1);

      // Start collision: encrypt wins; a decrypt pulse during LOAD is ignored
      cpu_shift = 8'd5;
      dc0 = done_cnt;
      start_job(1'b1, 1'b1, 5'd5);
      check("coll_prog", 32'(program_sel), 32'd1);
      repeat (3) @(negedge clk);
      start_job(1'b0, 1'b1, 5'd9);
      check("coll_prog_load", 32'(program_sel), 32'd1);
      wait_done("coll_done");
      check("coll_cfg_word", mem[2999], 32'h0000_0025);
      check("coll_done_cnt", 32'(done_cnt - dc0), 32'd1);
      repeat (5) @(negedge clk);
      check("coll_idle", 32'(busy), 32'd0);

      // Decrypt job with the CPU hung: watchdog runs 0..63, then readback anyway
      cpu_mode = 1; cpu_shift = 8'd1;
      rl0 = run_len; rb0 = rb_cnt; dc0 = done_cnt;
      start_job(1'b0, 1'b1, 5'd1);
      check("dec_prog", 32'(program_sel), 32'd2);
      wait_done("wd_done");
      check("dec_cfg_word", mem[2999], 32'h0000_0041);
      check("wd_timeout", 32'(timeout), 32'd1);
      check("wd_run_len", 32'(run_len - rl0), 32'd64);
      check("wd_rb_cnt", 32'(rb_cnt - rb0), 32'd108);
      check("wd_done_cnt", 32'(done_cnt - dc0), 32'd1);

      // Stale done on RUN entry: must stay in RUN until done returns at run cycle 20
      cpu_mode = 2; cpu_shift = 8'd2;
      rl0 = run_len;
      start_job(1'b1, 1'b0, 5'd2);
      check("stale_to_clear", 32'(timeout), 32'd0);
      wait_done("stale_done");
      check("stale_run_len", 32'(run_len - rl0), 32'd21);

      // Reset in READ with i = 40, then a fresh job starts from index 0
      cpu_mode = 0; cpu_shift = 8'd3;
      start_job(1'b1, 1'b0, 5'd3);
      n = 0;
      while (!(mem_re && mem_addr == 12'd3540) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("mid_reach_read40", {31'b0, mem_re && mem_addr == 12'd3540}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_strobes", {29'b0, mem_we, mem_re, rb_we}, 32'd0);
      check("mid_cpu_en_prog", {28'b0, cpu_en, program_sel}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_job(1'b1, 1'b0, 5'd3);
      check("mid_restart_addr", 32'(mem_addr), 32'd3000);
      check("mid_restart_data", mem_wdata, 32'h41);
      wait_done("mid_restart_done");

      // Blank handling: memory byte 0x05 and result bytes 0x00 / 0x41
      kbuf[2] = 8'h05; poke = 1'b1; cpu_shift = 8'd0;
      start_job(1'b1, 1'b0, 5'd0);
      wait_done("blank_done");
`ifdef XFER_SKIP_BLANK_EN
      check("blank_load", mem[3002], 32'h20);
      check("blank_rb0", 32'(rb[0]), 32'h20);
`else
      check("blank_load", mem[3002], 32'h05);
      check("blank_rb0", 32'(rb[0]), 32'h00);
`endif
      check("blank_rb1", 32'(rb[1]), 32'h41);
      check("strobe_overlap", 32'(overlap), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
